// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : Bundles the instruction channel, the result channel and the
//            combinational ALU bus of the issue controller.
//            master = surrounding system (instruction source, result sink,
//            ALU); slave = the issue controller itself.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
  // Instruction channel (valid/ready)
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;

  // Result channel (valid/ready)
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic [2:0]  result_rd;

  // Combinational ALU bus
  logic [31:0] alu_s1;
  logic [31:0] alu_s2;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_out;

  modport master (
    output instr_valid,
    input  instr_ready,
    output instr_data,
    input  result_valid,
    output result_ready,
    input  result_data,
    input  result_rd,
    input  alu_s1,
    input  alu_s2,
    input  alu_opcode,
    output alu_out
  );

  modport slave (
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    output result_valid,
    input  result_ready,
    output result_data,
    output result_rd,
    output alu_s1,
    output alu_s2,
    output alu_opcode,
    input  alu_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Instruction-issue controller for the combinational ALU. Accepts
//            an instruction, reads operands from a small register file,
//            presents them to the ALU, writes the result back and reports it
//            on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int NREGS = 8   // 2..8 registers, r0 is hard-wired to zero
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic             illegal_op,
  input  wire logic [2:0]  dbg_addr,
  output logic [31:0]      dbg_data
);

  // --------------------------------------------------------------------------
  // Opcodes understood by the ALU
  // --------------------------------------------------------------------------
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SGTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd13;

  // --------------------------------------------------------------------------
  // Controller states
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;

  // --------------------------------------------------------------------------
  // Instruction field decode
  // --------------------------------------------------------------------------
  logic [3:0]  dec_op;
  logic        dec_use_imm;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rs1;
  logic [2:0]  dec_rs2;
  logic [15:0] dec_imm;
  logic        unused_instr_bits;

  assign dec_op            = bus.instr_data[31:28];
  assign dec_use_imm       = bus.instr_data[27];
  assign dec_rd            = bus.instr_data[26:24];
  assign dec_rs1           = bus.instr_data[22:20];
  assign dec_rs2           = bus.instr_data[18:16];
  assign dec_imm           = bus.instr_data[15:0];
  // Bits 23 and 19 are reserved padding between register fields.
  assign unused_instr_bits = bus.instr_data[23] ^ bus.instr_data[19];

  // Register file; r0 has no storage and always reads as zero.
  logic [31:0] regs [1:NREGS-1];

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_sext;
  logic        op_legal;
  logic        accept;
  logic        wb_en;
  logic        wb_done;
  logic [2:0]  rd_q;

  // Sign-extended immediate operand.
  assign imm_sext = {{16{dec_imm[15]}}, dec_imm};

  // Classify the incoming opcode as supported or not.
  always_comb begin
    op_legal = 1'b0;
    case (dec_op)
      OP_ADD, OP_SLL, OP_SLT, OP_SGTU, OP_XOR,
      OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  // Register-file read ports: rs1, rs2 and the debug port. Indices that are
  // zero or beyond NREGS-1 read as zero.
  always_comb begin
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (dec_rs1 == 3'(i)) rs1_val = regs[i];
      if (dec_rs2 == 3'(i)) rs2_val = regs[i];
      if (dbg_addr == 3'(i)) dbg_data = regs[i];
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic. An illegal opcode is consumed in IDLE
  // without leaving it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && op_legal) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WB;
      S_WB:    if (bus.result_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs and datapath enables. instr_ready is also gated
  // by rst_n so nothing is offered as accepted while reset is held.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.instr_ready = 1'b0;
    wb_en           = 1'b0;
    wb_done         = 1'b0;
    case (state)
      S_IDLE:  bus.instr_ready = rst_n;
      S_ISSUE: wb_en           = 1'b1;
      S_WB:    wb_done         = bus.result_ready;
      default: ;
    endcase
  end

  assign accept = bus.instr_valid && bus.instr_ready;

  // ALU operand registers, illegal pulse and result port. ALU operands only
  // change on an accept so the ALU sees a full stable cycle in ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_s1       <= '0;
      bus.alu_s2       <= '0;
      bus.alu_opcode   <= '0;
      rd_q             <= '0;
      illegal_op       <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_data  <= '0;
      bus.result_rd    <= '0;
    end else begin
      illegal_op <= accept && !op_legal;
      if (accept) begin
        bus.alu_s1     <= rs1_val;
        bus.alu_s2     <= dec_use_imm ? imm_sext : rs2_val;
        bus.alu_opcode <= dec_op;
        rd_q           <= dec_rd;
      end
      if (wb_en) begin
        bus.result_valid <= 1'b1;
        bus.result_data  <= bus.alu_out;
        bus.result_rd    <= rd_q;
      end else if (wb_done) begin
        bus.result_valid <= 1'b0;
      end
    end
  end

  // Register-file write port: captures the ALU result at the end of ISSUE,
  // which completes before the next instruction can be accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_en && (rd_q == 3'(i))) regs[i] <= bus.alu_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl with an external ALU
//            model, a vector table and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam logic [3:0] ADD = 4'd0, SLL = 4'd1, SLT = 4'd2, SGTU = 4'd3,
                         XOR = 4'd4, SRL = 4'd5, OR = 4'd6, AND = 4'd7,
                         SUB = 4'd8, SRA = 4'd13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        illegal_op;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .illegal_op (illegal_op),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [3:0] op);
    case (op)
      ADD:     return a + b;
      SLL:     return a << b[4:0];
      SLT:     return {31'b0, $signed(a) < $signed(b)};
      SGTU:    return {31'b0, a > b};
      XOR:     return a ^ b;
      SRL:     return a >> b[4:0];
      OR:      return a | b;
      AND:     return a & b;
      SUB:     return a - b;
      SRA:     return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_s1, bus.alu_s2, bus.alu_opcode);

  int total = 0;
  int bad   = 0;
  int pushes = 0;
  int pops   = 0;

  logic [31:0] exp_data_q[$];
  logic [2:0]  exp_rd_q[$];

  typedef struct {
    logic [3:0]  op;
    logic        use_imm;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [31:0] exp;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vec[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
      pops++;
      if (exp_data_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h rd %0d expected none", bus.result_data, bus.result_rd);
      end else begin
        check("result_data", bus.result_data, exp_data_q.pop_front());
        check("result_rd", {29'b0, bus.result_rd}, {29'b0, exp_rd_q.pop_front()});
      end
    end
  end

  // Called at a negedge; returns 1 ns after the accepting posedge.
  task automatic issue(input logic [3:0] op, input logic use_imm, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
    bus.instr_data  = {op, use_imm, rd, 1'b0, rs1, 1'b0, rs2, imm};
    bus.instr_valid = 1'b1;
    check("instr_ready_idle", {31'b0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic expect_result(input logic [31:0] data, input logic [2:0] rd);
    exp_data_q.push_back(data);
    exp_rd_q.push_back(rd);
    pushes++;
  endtask

  // Waits (bounded) until the controller is back in IDLE; ends on a negedge.
  task automatic wait_idle();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got timeout expected instr_ready");
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    vec[0]  = '{ADD,  1'b1, 3'd1, 3'd0, 3'd0, 16'h0005, 32'h0000_0005, 32'h0000_0005};
    vec[1]  = '{ADD,  1'b1, 3'd2, 3'd0, 3'd0, 16'hFFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    vec[2]  = '{SUB,  1'b0, 3'd3, 3'd1, 3'd2, 16'h0000, 32'h0000_0008, 32'h0000_0008};
    vec[3]  = '{SLT,  1'b0, 3'd4, 3'd2, 3'd1, 16'h0000, 32'h0000_0001, 32'h0000_0001};
    vec[4]  = '{SGTU, 1'b0, 3'd5, 3'd2, 3'd1, 16'h0000, 32'h0000_0001, 32'h0000_0001};
    vec[5]  = '{SRA,  1'b1, 3'd6, 3'd2, 3'd0, 16'h0001, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    vec[6]  = '{SRL,  1'b1, 3'd7, 3'd2, 3'd0, 16'h0001, 32'h7FFF_FFFE, 32'h7FFF_FFFE};
    vec[7]  = '{XOR,  1'b0, 3'd3, 3'd1, 3'd2, 16'h0000, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
    vec[8]  = '{AND,  1'b0, 3'd4, 3'd1, 3'd2, 16'h0000, 32'h0000_0005, 32'h0000_0005};
    vec[9]  = '{OR,   1'b0, 3'd5, 3'd1, 3'd2, 16'h0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    vec[10] = '{SLL,  1'b1, 3'd6, 3'd1, 3'd0, 16'h0004, 32'h0000_0050, 32'h0000_0050};
    vec[11] = '{ADD,  1'b1, 3'd0, 3'd0, 3'd0, 16'h0007, 32'h0000_0007, 32'h0000_0000};

    rst_n            = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.instr_data   = '0;
    bus.result_ready = 1'b1;
    dbg_addr         = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_ready", {31'b0, bus.instr_ready}, 32'd0);
    check("rst_result_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_result_data", bus.result_data, 32'd0);
    check("rst_alu_s1", bus.alu_s1, 32'd0);
    check("rst_alu_s2", bus.alu_s2, 32'd0);
    check("rst_alu_opcode", {28'b0, bus.alu_opcode}, 32'd0);
    check("rst_illegal", {31'b0, illegal_op}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, bus.instr_ready}, 32'd1);

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      expect_result(vec[i].exp, vec[i].rd);
      issue(vec[i].op, vec[i].use_imm, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].imm);
      wait_idle();
      check_reg("reg_after_wb", vec[i].rd, vec[i].exp_reg);
    end

    // Backpressure: hold result_ready low while another instruction is offered
    @(negedge clk);
    bus.result_ready = 1'b0;
    expect_result(32'h0000_0011, 3'd1);
    issue(ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0011);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    check("bp_valid_seen", {31'b0, seen}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.instr_data  = {ADD, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0022};
      bus.instr_valid = 1'b1;
      check("bp_result_valid", {31'b0, bus.result_valid}, 32'd1);
      check("bp_result_data", bus.result_data, 32'h0000_0011);
      check("bp_instr_ready", {31'b0, bus.instr_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.instr_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_ready", {31'b0, bus.instr_ready}, 32'd0);
    @(negedge clk);
    check("bp_back_idle", {31'b0, bus.instr_ready}, 32'd1);
    check("bp_valid_cleared", {31'b0, bus.result_valid}, 32'd0);
    check_reg("bp_r1", 3'd1, 32'h0000_0011);
    check_reg("bp_r2_untouched", 3'd2, 32'hFFFF_FFFD);

    // Illegal opcode
    @(negedge clk);
    check("illegal_before", {31'b0, illegal_op}, 32'd0);
    issue(4'b1010, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0055);
    @(negedge clk);
    check("illegal_pulse", {31'b0, illegal_op}, 32'd1);
    check("illegal_ready", {31'b0, bus.instr_ready}, 32'd1);
    check("illegal_no_result", {31'b0, bus.result_valid}, 32'd0);
    @(negedge clk);
    check("illegal_pulse_end", {31'b0, illegal_op}, 32'd0);
    check("illegal_no_result2", {31'b0, bus.result_valid}, 32'd0);
    check_reg("illegal_r1", 3'd1, 32'h0000_0011);

    // Reset during ISSUE
    @(negedge clk);
    issue(ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0009);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_result_valid", {31'b0, bus.result_valid}, 32'd0);
    check("midrst_result_data", bus.result_data, 32'd0);
    check("midrst_alu_s2", bus.alu_s2, 32'd0);
    check("midrst_alu_opcode", {28'b0, bus.alu_opcode}, 32'd0);
    check("midrst_instr_ready", {31'b0, bus.instr_ready}, 32'd0);
    check_reg("midrst_r1", 3'd1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", {31'b0, bus.instr_ready}, 32'd1);
    check("midrst_valid_after", {31'b0, bus.result_valid}, 32'd0);
    check_reg("midrst_r1_after", 3'd1, 32'd0);
    check_reg("midrst_r2_after", 3'd2, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_data_q.size(), 32'd0);
    check("sb_pops", pops, pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
